ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
- Fetch stage directly downstream of the PC generator. It takes each PC, issues an instruction-memory read, and collects in-order responses into a DEPTH-entry queue.
- Delivers {pc, inst, fault} to decode over a valid/ready handshake.
- Back-pressures the PC generator via pc_ready.
- On branch redirect (flush), drops queued and in-flight fetches.

Parameters:
- XLEN, 32, address/PC width.
- DEPTH, 4, queue entries (power of 2, >=2); also the maximum number of outstanding memory requests.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- pc_valid  input  1  PC generator offers a PC.
- pc  input  XLEN  PC to fetch.
- pc_ready  output  1  PC accepted this cycle when pc_valid & pc_ready.
- flush  input  1  redirect; kill all entries and in-flight fetches.
- imem_req_valid  output  1  memory read request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  read address (equals pc, word aligned).
- imem_rsp_valid  input  1  read data returned; in order; always accepted.
- imem_rsp_data  input  32  instruction word.
- imem_rsp_err  input  1  access fault for this response.
- inst_valid  output  1  head entry ready for decode.
- inst_ready  input  1  decode accepts.
- inst_pc  output  XLEN  PC of head entry.
- inst  output  32  instruction of head entry (0 when fault).
- inst_fault  output  1  head entry faulted (misaligned or rsp_err).

Behaviour:
- Storage: circular queue of DEPTH entries {pc, inst, fault, filled}.
- Pointers: head (pop), fill (next entry awaiting response), tail (alloc). Each is log2(DEPTH) bits and wraps modulo DEPTH.
- count = allocated entries, 0..DEPTH, held in a separate counter.
- drop_cnt = responses still to discard, 0..DEPTH.
- Accept condition: accept = pc_valid & !flush & count<DEPTH & drop_cnt==0 & (misaligned | imem_req_ready), where misaligned = pc[1:0]!=0.
- pc_ready and imem_req_valid:
  - pc_ready = !flush & count<DEPTH & drop_cnt==0 & (misaligned | imem_req_ready); fully combinational.
  - imem_req_valid = pc_valid & !misaligned & !flush & count<DEPTH & drop_cnt==0.
  - imem_req_addr = pc.
- Aligned accept: allocate entry at tail with pc, filled=0; tail++, count++.
- Misaligned accept: no memory request. Allocate entry with filled=1, fault=1, inst=0. The fill pointer skips this entry in order.
- Response when drop_cnt==0 and no flush:
  - Write inst=imem_rsp_data and fault=imem_rsp_err into the entry at fill, with filled=1.
  - If imem_rsp_err=1, store inst=0.
  - Advance fill past any pre-filled misaligned entries.
- Response when drop_cnt>0: discard and decrement drop_cnt.
- Output: inst_valid = (count>0) & filled[head] & !flush. Pop on inst_valid & inst_ready: head++, count--.
- Latency: the earliest inst_valid is the cycle after the response edge that filled the entry. There is no combinational path from rsp to inst.
- Flush cycle:
  - No accept, no pop, no request.
  - At the edge: head=tail=fill, count=0.
  - drop_cnt is set to (current drop_cnt) + (number of issued-but-unanswered requests).
  - A response arriving in the flush cycle is discarded and is not counted in that number.
- Simultaneous events:
  - Accept and pop in the same cycle leave count unchanged.
  - Response and accept in the same cycle are both processed.
  - count==DEPTH with a pop in that cycle does not permit an accept in the same cycle; pc_ready uses the pre-pop count.
- Overrun: a response with no outstanding request and drop_cnt==0 is a protocol violation. The block ignores it; the bench asserts it never happens.
- Reset (rst=1 at an edge):
  - count=0, drop_cnt=0, all pointers 0, all filled=0.
  - Outputs: inst_valid=0, imem_req_valid=0, pc_ready=0.
  - A reset mid-operation abandons in-flight requests. Memory is reset in the same cycle.
- Stability: imem_req_valid, once asserted, is not required to hold; requests are combinational offers.

Test Plan:
- Streaming: pc 0x0,0x4,0x8,0xC with 1-cycle memory latency, inst_ready=1. Required: inst 0x00000013 etc. emitted in order with matching inst_pc; sustained one instruction per cycle after the first.
- Back-pressure: inst_ready=0, 1-cycle memory. Required: 4 PCs accepted, then pc_ready=0 with count=4. Raising inst_ready pops 0x0 first; pc_ready reasserts the next cycle.
- Flush with 2 in flight: issue 0x10,0x14, then assert flush before either response. Required: drop_cnt=2; both later responses dropped; pc_ready=0 until drop_cnt=0; next PC 0x100 returns its own data.
- Misaligned: pc=0x6 between 0x0 and 0x8. Required: no imem request for 0x6; decode sees 0x0, then {0x6, inst=0, fault=1}, then 0x8, in order.
- Response error: imem_rsp_err=1 for pc 0x20. Required: inst_fault=1, inst=0, inst_pc=0x20; following entries unaffected.
- Reset mid-stream: rst=1 for one cycle with 3 entries queued. Required: next cycle inst_valid=0, pc_ready=0, imem_req_valid=0; after release, fetch of 0x0 proceeds normally.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue
//   Fetch stage sitting behind the PC generator. Every accepted PC allocates a
//   queue entry. Aligned PCs issue an instruction-memory read. Misaligned PCs
//   are stored immediately as faulted entries and issue no read. In-order
//   responses fill the oldest waiting entry, and the head entry is handed to
//   decode in program order. A flush drops every queued entry. Responses still
//   owed for requests issued before the flush are counted and discarded when
//   they arrive.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pc_valid/pc/pc_ready     PC generator handshake
//   flush                    branch redirect, kills queue and in-flight fetches
//   imem_req_valid/ready     memory read request handshake, imem_req_addr = pc
//   imem_rsp_valid/data/err  in-order read responses, always accepted
//   inst_valid/inst_ready    decode handshake
//   inst_pc/inst/inst_fault  head entry contents (inst = 0 when faulted)
module ifu_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] pc,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     inst,
  output logic            inst_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry payload
  logic [XLEN-1:0]  r_pc    [DEPTH];
  logic [31:0]      r_inst  [DEPTH];
  logic [DEPTH-1:0] r_fault;
  logic [DEPTH-1:0] r_filled;

  // Control state
  logic [PW-1:0] r_head, r_fill, r_tail;
  logic [CW-1:0] r_count;  // allocated entries
  logic [CW-1:0] r_drop;   // responses still to discard after a flush
  logic [CW-1:0] r_outst;  // issued requests not yet answered

  logic            w_misaligned, w_room, w_accept, w_req_fire, w_pop;
  logic            w_rsp_take, w_rsp_drop, w_found;
  logic [PW-1:0]   w_head_nxt, w_tail_nxt, w_fill_nxt, w_idx;
  logic [CW-1:0]   w_count_nxt, w_pending, w_drop_flush;
  logic [DEPTH-1:0] w_filled_nxt;

  assign w_misaligned = (pc[1:0] != 2'b00);
  // Room to take a PC. Reset is included so the handshakes are quiet while
  // rst is held.
  assign w_room = !rst && !flush && (r_count < DEPTH_C) && (r_drop == '0);

  assign pc_ready       = w_room && (w_misaligned || imem_req_ready);
  assign imem_req_valid = w_room && pc_valid && !w_misaligned;
  assign imem_req_addr  = pc;

  assign w_accept   = pc_valid && pc_ready;
  assign w_req_fire = w_accept && !w_misaligned;

  assign inst_valid = !rst && !flush && (r_count != '0) && r_filled[r_head];
  assign inst_pc    = r_pc[r_head];
  assign inst       = r_inst[r_head];
  assign inst_fault = r_fault[r_head];
  assign w_pop      = inst_valid && inst_ready;

  // Responses are consumed in order: while drops are owed they are discarded,
  // otherwise they belong to the entry at the fill pointer.
  assign w_rsp_drop = imem_rsp_valid && !rst && !flush && (r_drop != '0);
  assign w_rsp_take = imem_rsp_valid && !rst && !flush && (r_drop == '0) &&
                      (r_outst != '0);

  assign w_head_nxt  = r_head + PW'(w_pop);
  assign w_tail_nxt  = r_tail + PW'(w_accept);
  assign w_count_nxt = r_count + CW'(w_accept) - CW'(w_pop);

  // Next filled map, then the fill pointer moves to the oldest allocated entry
  // still waiting for data. Pre-filled misaligned entries are skipped. When no
  // entry is waiting, it parks at the tail.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_filled_nxt = r_filled;
    w_fill_nxt   = w_tail_nxt;
    w_found      = 1'b0;
    w_idx        = '0;
    if (w_pop)      w_filled_nxt[r_head] = 1'b0;
    if (w_rsp_take) w_filled_nxt[r_fill] = 1'b1;
    if (w_accept)   w_filled_nxt[r_tail] = w_misaligned;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_head_nxt + PW'(k);
      if (!w_found && (CW'(k) < w_count_nxt) && !w_filled_nxt[w_idx]) begin
        w_fill_nxt = w_idx;
        w_found    = 1'b1;
      end
    end
  end

  // On flush, owed responses = earlier drops + unanswered requests. A response
  // arriving in the flush cycle answers one of them.
  always_comb begin
    w_pending    = r_drop + r_outst;
    w_drop_flush = w_pending;
    if (imem_rsp_valid && (w_pending != '0)) w_drop_flush = w_pending - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= '0;
      r_fill   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_drop   <= '0;
      r_outst  <= '0;
      r_filled <= '0;
    end else if (flush) begin
      r_head   <= r_tail;
      r_fill   <= r_tail;
      r_count  <= '0;
      r_filled <= '0;
      r_outst  <= '0;
      r_drop   <= w_drop_flush;
    end else begin
      r_head   <= w_head_nxt;
      r_tail   <= w_tail_nxt;
      r_fill   <= w_fill_nxt;
      r_count  <= w_count_nxt;
      r_filled <= w_filled_nxt;
      r_outst  <= r_outst + CW'(w_req_fire) - CW'(w_rsp_take);
      r_drop   <= r_drop - CW'(w_rsp_drop);
    end
  end

  // NOTE: payload storage is not reset; r_filled and r_count gate every read of it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pc[r_tail]    <= pc;
      r_inst[r_tail]  <= '0;
      r_fault[r_tail] <= w_misaligned;
    end
    if (w_rsp_take) begin
      r_inst[r_fill]  <= imem_rsp_err ? 32'h0 : imem_rsp_data;
      r_fault[r_fill] <= imem_rsp_err;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Self-checking bench for ifu_fetch_queue.
// The PC side pushes the expected decode entry whenever a PC is accepted.
// A decode monitor pops and compares each delivered entry.
// A behavioural memory answers requests in order after a programmable latency.
module tb_ifu_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pc_valid = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic            pc_ready;
  logic            flush = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b1;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            imem_rsp_err = 1'b0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [XLEN-1:0] inst_pc;
  logic [31:0]     inst;
  logic            inst_fault;

  ifu_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
    .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst(inst), .inst_fault(inst_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  exp_t exp_q[$];
  req_t pend[$];
  int   pop_cyc[$];
  int   rsp_seen = 0;
  int   lat_lo = 1, lat_hi = 1;
  bit   mem_rand = 1'b0;

  // Memory contents: pc 0 holds 0x00000013. Every address whose bits [7:2] are 0x08 faults.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[26:0], 5'b0} ^ 32'h0000_0013;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[7:2] == 6'h08;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  // PC side: record what decode must eventually see for every accepted PC.
  exp_t acc_e;
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else if (pc_valid && pc_ready) begin
      acc_e.pc = pc;
      if (pc[1:0] != 2'b00) begin
        acc_e.inst  = '0;
        acc_e.fault = 1'b1;
      end else begin
        acc_e.fault = mem_err(pc);
        acc_e.inst  = acc_e.fault ? 32'h0 : mem_data(pc);
      end
      exp_q.push_back(acc_e);
    end
  end

  // Decode side monitor.
  exp_t mon_e;
  always @(negedge clk) begin
    if (inst_valid && inst_ready) begin
      check("scoreboard has entry at pop", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("inst_pc", 64'(inst_pc), 64'(mon_e.pc));
        check("inst", 64'(inst), 64'(mon_e.inst));
        check("inst_fault", 64'(inst_fault), 64'(mon_e.fault));
      end
      pop_cyc.push_back(cyc);
    end
  end

  // Memory: take requests, answer in order no earlier than the due cycle.
  req_t mem_r;
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
    end else begin
      if (imem_rsp_valid) begin
        rsp_seen++;
        if (pend.size() != 0) void'(pend.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        check("imem_req_addr", 64'(imem_req_addr), 64'(pc));
        check("request only for aligned pc", 64'(pc[1:0]), 64'(0));
        mem_r.addr = imem_req_addr;
        mem_r.due  = cyc + lat_lo + int'($urandom % 32'(lat_hi - lat_lo + 1));
        pend.push_back(mem_r);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    imem_req_ready = mem_rand ? ($urandom % 4 != 0) : 1'b1;
    if (pend.size() != 0 && pend[0].due <= cyc && (!mem_rand || $urandom % 3 != 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(pend[0].addr);
      imem_rsp_err   = mem_err(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      imem_rsp_err   = 1'($urandom);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a PC until it is accepted (bounded), and report the accept cycle.
  task automatic offer(input logic [31:0] p, output int acc_cyc);
    bit done = 1'b0;
    int guard = 0;
    acc_cyc  = -1;
    pc_valid = 1'b1;
    pc       = p;
    while (!done && guard < 50) begin
      @(negedge clk);
      if (pc_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
      step();
      guard++;
    end
    if (!done) check("pc accepted within budget", 64'(done), 64'(1));
    pc_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int g = 0;
    while ((exp_q.size() != 0 || pend.size() != 0) && g < budget) begin
      step();
      g++;
    end
    check("drain completes", 64'(exp_q.size() + pend.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, dummy, g, rs0;
    logic [31:0] r;

    // Reset: handshakes quiet while rst is held, even with a PC offered.
    rst = 1'b1; pc_valid = 1'b1; pc = 32'h0;
    step();
    @(negedge clk);
    check("reset pc_ready", 64'(pc_ready), 64'(0));
    check("reset imem_req_valid", 64'(imem_req_valid), 64'(0));
    check("reset inst_valid", 64'(inst_valid), 64'(0));
    step();
    rst = 1'b0; pc_valid = 1'b0;
    @(negedge clk);
    check("post-reset inst_valid", 64'(inst_valid), 64'(0));
    check("post-reset pc_ready", 64'(pc_ready), 64'(1));
    step();

    // Streaming, 1-cycle memory, decode always ready.
    inst_ready = 1'b1;
    pop_cyc.delete();
    offer(32'h0, a0);
    offer(32'h4, dummy);
    offer(32'h8, dummy);
    offer(32'hC, dummy);
    g = 0;
    while (pop_cyc.size() < 4 && g < 30) begin step(); g++; end
    check("stream pop count", 64'(pop_cyc.size()), 64'(4));
    if (pop_cyc.size() >= 4) begin
      check("stream first latency", 64'(pop_cyc[0] - a0), 64'(2));
      check("stream one per cycle", 64'(pop_cyc[3] - pop_cyc[0]), 64'(3));
    end
    drain(50);

    // Back-pressure: decode stalled, queue fills to DEPTH.
    inst_ready = 1'b0;
    offer(32'h0, dummy);
    offer(32'h4, dummy);
    offer(32'h8, dummy);
    offer(32'hC, dummy);
    pc_valid = 1'b1; pc = 32'h10;
    @(negedge clk);
    check("full pc_ready", 64'(pc_ready), 64'(0));
    repeat (3) step();
    inst_ready = 1'b1;
    @(negedge clk);
    check("pc_ready uses pre-pop count", 64'(pc_ready), 64'(0));
    check("head valid when full", 64'(inst_valid), 64'(1));
    check("head pc when full", 64'(inst_pc), 64'(32'h0));
    step();
    @(negedge clk);
    check("pc_ready after pop", 64'(pc_ready), 64'(1));
    step();
    pc_valid = 1'b0;
    drain(50);

    // Flush with two requests in flight, slow memory.
    lat_lo = 4; lat_hi = 4;
    offer(32'h10, dummy);
    offer(32'h14, dummy);
    flush = 1'b1; pc_valid = 1'b1; pc = 32'h100;
    rs0 = rsp_seen;
    @(negedge clk);
    check("flush pc_ready", 64'(pc_ready), 64'(0));
    check("flush imem_req_valid", 64'(imem_req_valid), 64'(0));
    check("flush inst_valid", 64'(inst_valid), 64'(0));
    step();
    flush = 1'b0;
    @(negedge clk);
    check("pc_ready low while dropping", 64'(pc_ready), 64'(0));
    g = 0;
    while (!pc_ready && g < 20) begin
      step();
      @(negedge clk);
      g++;
    end
    check("pc_ready back after drops", 64'(pc_ready), 64'(1));
    check("responses dropped before pc_ready", 64'(rsp_seen - rs0), 64'(2));
    step();
    pc_valid = 1'b0;
    drain(50);

    // Misaligned PC behind an outstanding fetch.
    lat_lo = 3; lat_hi = 3;
    offer(32'h0, dummy);
    pc_valid = 1'b1; pc = 32'h6;
    @(negedge clk);
    check("misaligned no request", 64'(imem_req_valid), 64'(0));
    check("misaligned pc_ready", 64'(pc_ready), 64'(1));
    step();
    pc_valid = 1'b0;
    offer(32'h8, dummy);
    drain(50);

    // Response error on 0x20; neighbours unaffected.
    lat_lo = 1; lat_hi = 1;
    offer(32'h1C, dummy);
    offer(32'h20, dummy);
    offer(32'h24, dummy);
    drain(50);

    // Reset with three entries queued.
    inst_ready = 1'b0;
    offer(32'h0, dummy);
    offer(32'h4, dummy);
    offer(32'h8, dummy);
    repeat (3) step();
    rst = 1'b1; pc_valid = 1'b1; pc = 32'hC;
    @(negedge clk);
    check("mid reset inst_valid", 64'(inst_valid), 64'(0));
    check("mid reset pc_ready", 64'(pc_ready), 64'(0));
    check("mid reset imem_req_valid", 64'(imem_req_valid), 64'(0));
    step();
    rst = 1'b0; pc_valid = 1'b0;
    @(negedge clk);
    check("after reset queue empty", 64'(inst_valid), 64'(0));
    step();
    inst_ready = 1'b1;
    offer(32'h0, dummy);
    drain(50);

    // Randomized traffic with random memory timing and occasional flushes.
    mem_rand = 1'b1; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      r        = $urandom;
      pc_valid = ($urandom % 4 != 0);
      pc       = r & 32'h0000_03FC;
      if (r[31:29] == 3'b000) pc[1:0] = 2'(1 + $urandom % 3);
      flush      = ($urandom % 40 == 0);
      inst_ready = ($urandom % 3 != 0);
      step();
    end
    pc_valid = 1'b0; flush = 1'b0; inst_ready = 1'b1; mem_rand = 1'b0;
    drain(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
